// File: rtl/alu_6502_pkg.sv
// Shared encodings for the 6502 ALU writeback slice: control one-hots, flag indices, FIFO states.
// No logic of its own; the legality helper is pure combinational.
// No flow control here; consumers handle backpressure.
package alu_6502_pkg;

    localparam logic [4:0] CTRL_SUMS = 5'b10000;
    localparam logic [4:0] CTRL_ORS  = 5'b01000;
    localparam logic [4:0] CTRL_XORS = 5'b00100;
    localparam logic [4:0] CTRL_ANDS = 5'b00010;
    localparam logic [4:0] CTRL_SRS  = 5'b00001;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef logic [2:0] flags_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

    function automatic logic ctrl_legal(input logic [4:0] ctrl);
        logic w_ok;
        case (ctrl)
            CTRL_SUMS, CTRL_ORS, CTRL_XORS, CTRL_ANDS, CTRL_SRS: w_ok = 1'b1;
            default:                                             w_ok = 1'b0;
        endcase
        return w_ok;
    endfunction

endpackage

// File: rtl/alu_6502_wb_fifo.sv
// Small circular FIFO holding {flags, result} entries for the stage after writeback.
// Latency: a pushed entry is visible at o_rdata the cycle after the push.
// Backpressure: o_full derives from registered count only; caller must not push when full.
module alu_6502_wb_fifo
    import alu_6502_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    fifo_state_t      w_state;

    // Storage carries no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state = FIFO_PARTIAL;
        if (r_count == '0) begin
            w_state = FIFO_EMPTY;
        end else if (r_count == CW'(DEPTH)) begin
            w_state = FIFO_FULL;
        end
    end

    assign o_full  = (w_state == FIFO_FULL);
    assign o_empty = (w_state == FIFO_EMPTY);
    assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_6502_wb.sv
// Writeback after the 6502 ALU: updates A and N/V/Z, flags illegal controls, queues {flags,result}.
// Latency: A/flags one cycle after accept; queued entry at out_data one cycle after accept at earliest.
// Backpressure: in_ready = FIFO not full (registered only); optional counters under ALU6502_WB_PERF_EN.
module alu_6502_wb
    import alu_6502_pkg::*;
#(
    parameter int         DEPTH     = 2,
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_result,
    input  logic        in_overflow,
    input  logic [4:0]  in_control,
    input  logic        in_wr_acc,
    output logic [7:0]  acc,
    output logic [2:0]  flags,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_data
`ifdef ALU6502_WB_PERF_EN
    ,
    output logic [15:0] perf_cnt,
    output logic [15:0] stall_cnt
`endif
);

    logic [7:0] r_acc;
    flags_t     r_flags;
    logic       r_err;
    flags_t     w_new_flags;
    logic       w_accept;
    logic       w_legal;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;

    assign w_legal  = ctrl_legal(in_control);
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & w_legal;
    assign w_pop    = out_valid & out_ready;

    // V only tracks the adder; logic and shift ops leave it as it was.
    always_comb begin
        w_new_flags         = r_flags;
        w_new_flags[FLAG_N] = in_result[7];
        w_new_flags[FLAG_Z] = (in_result == 8'h00);
        if (in_control == CTRL_SUMS) begin
            w_new_flags[FLAG_V] = in_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= ACC_RESET;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_flags <= w_new_flags;
                if (in_wr_acc) begin
                    r_acc <= in_result;
                end
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    alu_6502_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (11)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({w_new_flags, in_result}),
        .o_rdata (out_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign acc       = r_acc;
    assign flags     = r_flags;
    assign err       = r_err;

`ifdef ALU6502_WB_PERF_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_perf_cnt <= r_perf_cnt + 16'd1;
            end
            if (in_valid && !in_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign perf_cnt  = r_perf_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_6502_wb.sv
// Bench for alu_6502_wb: table of sequential ops plus hand sequences for backpressure and reset.
module tb_alu_6502_wb;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_result;
    logic        in_overflow;
    logic [4:0]  in_control;
    logic        in_wr_acc;
    logic [7:0]  acc;
    logic [2:0]  flags;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
`ifdef ALU6502_WB_PERF_EN
    logic [15:0] perf_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    alu_6502_wb #(.DEPTH(2), .ACC_RESET(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_overflow (in_overflow),
        .in_control  (in_control),
        .in_wr_acc   (in_wr_acc),
        .acc         (acc),
        .flags       (flags),
        .err         (err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
`ifdef ALU6502_WB_PERF_EN
        ,
        .perf_cnt    (perf_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctrl;
        logic [7:0]  res;
        logic        ovf;
        logic        wr;
        logic [7:0]  exp_acc;
        logic [2:0]  exp_flags;
        logic        exp_err;
        logic        exp_push;
        logic [10:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] c, input logic [7:0] r, input logic o, input logic w);
        in_control  = c;
        in_result   = r;
        in_overflow = o;
        in_wr_acc   = w;
        in_valid    = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 10) begin
            tick();
            n++;
        end
        tick();
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    // Pops are compared half a cycle before the edge that performs them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_data_unexpected actual=%0h expected=none", out_data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL out_data actual=%0h expected=%0h", out_data, e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{5'b10000, 8'h80, 1'b1, 1'b1, 8'h80, 3'b110, 1'b0, 1'b1, 11'h680};
        vecs[1] = '{5'b01000, 8'h00, 1'b1, 1'b0, 8'h80, 3'b011, 1'b0, 1'b1, 11'h300};
        vecs[2] = '{5'b10000, 8'h7F, 1'b0, 1'b1, 8'h7F, 3'b000, 1'b0, 1'b1, 11'h07F};
        vecs[3] = '{5'b00010, 8'hFF, 1'b1, 1'b1, 8'hFF, 3'b100, 1'b0, 1'b1, 11'h4FF};
        vecs[4] = '{5'b00100, 8'h01, 1'b0, 1'b0, 8'hFF, 3'b000, 1'b0, 1'b1, 11'h001};
        vecs[5] = '{5'b00001, 8'h00, 1'b1, 1'b1, 8'h00, 3'b001, 1'b0, 1'b1, 11'h100};
        vecs[6] = '{5'b10000, 8'h00, 1'b1, 1'b1, 8'h00, 3'b011, 1'b0, 1'b1, 11'h300};
        vecs[7] = '{5'b11000, 8'h55, 1'b0, 1'b1, 8'h00, 3'b011, 1'b1, 1'b0, 11'h000};
        vecs[8] = '{5'b00000, 8'hAA, 1'b0, 1'b1, 8'h00, 3'b011, 1'b1, 1'b0, 11'h000};
        vecs[9] = '{5'b01000, 8'h55, 1'b0, 1'b1, 8'h55, 3'b010, 1'b1, 1'b1, 11'h255};

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_result   = 8'h00;
        in_overflow = 1'b0;
        in_control  = 5'b00000;
        in_wr_acc   = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        check("rst_acc", acc, 8'h00);
        check("rst_flags", flags, 3'b000);
        check("rst_err", err, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ctrl, vecs[i].res, vecs[i].ovf, vecs[i].wr);
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].exp_data);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            tick();
            check($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end
        drain("table");

        // Fill to full with no drain, then offer a third entry across a pop.
        out_ready = 1'b0;
        drive(5'b10000, 8'h01, 1'b0, 1'b1);
        exp_q.push_back(11'h001);
        tick();
        check("bp_in_ready_1", in_ready, 1'b1);
        check("bp_out_data_1", out_data, 11'h001);
        drive(5'b01000, 8'h80, 1'b0, 1'b0);
        exp_q.push_back(11'h480);
        tick();
        check("bp_in_ready_full", in_ready, 1'b0);
        drive(5'b00100, 8'h02, 1'b0, 1'b0);
        exp_q.push_back(11'h002);
        tick();
        check("bp_held_in_ready", in_ready, 1'b0);
        check("bp_out_data_stable", out_data, 11'h001);
        check("bp_flags_held", flags, 3'b100);
        out_ready = 1'b1;
        tick();
        check("full_pop_in_ready", in_ready, 1'b1);
        check("full_pop_no_accept", flags, 3'b100);
        out_ready = 1'b0;
        tick();
        check("full_retry_accept", flags, 3'b000);
        check("full_retry_in_ready", in_ready, 1'b0);
        check("bp_acc", acc, 8'h01);
        check("err_sticky", err, 1'b1);
        drain("bp");

        // Reset with two entries queued discards them.
        out_ready = 1'b0;
        drive(5'b00010, 8'h00, 1'b0, 1'b1);
        tick();
        drive(5'b10000, 8'hC0, 1'b1, 1'b1);
        tick();
        check("pre_rst_acc", acc, 8'hC0);
        check("pre_rst_flags", flags, 3'b110);
        check("pre_rst_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_acc", acc, 8'h00);
        check("mid_rst_flags", flags, 3'b000);
        check("mid_rst_err", err, 1'b0);
        out_ready = 1'b1;
        drive(5'b10000, 8'h00, 1'b0, 1'b1);
        exp_q.push_back(11'h100);
        tick();
        check("post_rst_flags", flags, 3'b001);
        drain("post_rst");

`ifdef ALU6502_WB_PERF_EN
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        drive(5'b10000, 8'h01, 1'b0, 1'b0);
        exp_q.push_back(11'h001);
        exp_q.push_back(11'h001);
        for (int i = 0; i < 5; i++) tick();
        check("perf_cnt_2", perf_cnt, 16'd2);
        check("stall_cnt_3", stall_cnt, 16'd3);
        drain("perf_stall");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] r;
            r = i[7:0];
            drive(5'b10000, r, 1'b0, 1'b1);
            exp_q.push_back({r[7], 1'b0, (r == 8'h00), r});
            tick();
        end
        check("perf_wrap", perf_cnt, 16'd0);
        check("stall_none", stall_cnt, 16'd0);
        drain("perf_wrap");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
